uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Memory-mapped controller between the Riscv151 CPU data-memory port and the on-chip `uart`. It decodes CPU loads and stores in the 0x8000_00xx I/O window and buffers bytes in both directions with small FIFOs. It sequences the UART ready/valid handshakes so software polls a status word instead of the raw UART strobes. It also keeps sticky error flags that software can read and clear.

## Interface
Parameters:
- `RX_DEPTH`, 8: RX FIFO entries; power of 2, ≥2.
- `TX_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  **synchronous, active-high reset**.
- `addr`  in  32  CPU byte address; valid when `re` or `we` is high.
- `wdata`  in  32  CPU store data.
- `we`  in  1  store strobe, one cycle per store.
- `re`  in  1  load strobe, one cycle per load.
- `rdata`  out  32  load result, registered.
- `uart_tx_data`  out  8  drives `uart.data_in`.
- `uart_tx_valid`  out  1  drives `uart.data_in_valid`.
- `uart_tx_ready`  in  1  from `uart.data_in_ready`.
- `uart_rx_data`  in  8  from `uart.data_out`.
- `uart_rx_valid`  in  1  from `uart.data_out_valid`.
- `uart_rx_ready`  out  1  drives `uart.data_out_ready`.

## Operation
Address decode:
- The block is selected when `addr[31:28]==4'h8`.
- The register is chosen by `addr[3:2]`.
- `addr[1:0]` and all other bits are ignored.

Register map:
- 0x80000000 STATUS (read-only): bit0 = TX FIFO not full, bit1 = RX FIFO not empty, bit2 = RX overrun sticky, bit3 = TX overflow sticky, bit4 = TX FIFO empty, other bits 0.
- 0x80000004 RXDATA (read): returns `{24'b0, head}` and pops the RX FIFO. If the RX FIFO is empty, returns 0 and does not pop.
- 0x80000008 TXDATA (write): pushes `wdata[7:0]`. If the TX FIFO is full, the byte is dropped and TX overflow is set.
- 0x8000000C CTRL (write): any write clears both sticky bits. Bit0 set additionally flushes both FIFOs.

General access rules:
- A read of a write-only register returns 0.
- A write to a read-only register is ignored.
- Unselected accesses leave all state unchanged and load 0 into `rdata`.

TX engine:
- `uart_tx_valid` = TX FIFO not empty.
- `uart_tx_data` = TX FIFO head.
- The head is popped on a cycle where both `uart_tx_valid` and `uart_tx_ready` are high.

RX engine:
- `uart_rx_ready` = RX FIFO not full, forced to 0 while `rst` is high.
- A byte is pushed on a cycle where both `uart_rx_valid` and `uart_rx_ready` are high.
- RX overrun is set on any cycle where `uart_rx_valid` is high and the RX FIFO is full. The UART retains the byte; nothing is lost in this block.

## Timing
Reset:
- Both FIFOs are empty.
- Sticky bits are 0.
- `rdata` = 0, `uart_tx_valid` = 0, `uart_rx_ready` = 0.
- Reset asserted mid-transfer discards all buffered bytes. The UART keeps any in-flight serial frame.

Loads and stores:
- Load latency is 1 cycle: `rdata` is valid the cycle after `re`, matching synchronous BIOS/data memory. `rdata` holds until the next `re`.
- STATUS reflects state at the start of the `re` cycle, before same-cycle pushes or pops.
- A TXDATA store is visible on `uart_tx_valid` the next cycle, so the minimum store-to-handshake latency is 1 cycle.
- A byte accepted from the UART is readable via RXDATA from the next cycle onward.

FIFO full/empty and simultaneous events:
- Full and empty flags come from registered counts. A push into a full FIFO is refused even if a pop happens in the same cycle.
- A simultaneous push and pop on a non-empty FIFO leaves the count unchanged and keeps ordering.
- Pointers wrap modulo DEPTH; counts are `$clog2(DEPTH)+1` bits wide.

CTRL write in the same cycle as other events:
- A CTRL flush overrides any same-cycle push or pop.
- Sticky-bit clear loses to a same-cycle set: the bit stays 1.

## Structure
- Package `uart_mmio_pkg` contains:
  - the base nibble 4'h8;
  - register offset constants STATUS/RXDATA/TXDATA/CTRL;
  - STATUS bit index constants;
  - CTRL flush bit index.
- One sub-module, `sync_fifo`, parameterised by WIDTH and DEPTH:
  - ports: push/pop/full/empty/count, flush, head output;
  - instantiated twice, with WIDTH=8, DEPTH=RX_DEPTH/TX_DEPTH.
- The top level contains address decode, the `rdata` register, the sticky flags and the handshake glue.

## Test plan
- Echo: off-chip UART sends 0x7A, then CPU-model polls STATUS until bit1 = 1 → RXDATA returns 0x0000007A. Writing 0x7A to TXDATA → off-chip UART receives 0x7A.
- Burst TX: store 0x41..0x48 back-to-back with `uart_tx_ready` held low → STATUS bit0 = 0 after the 8th store. A 9th store of 0x49 → dropped, STATUS bit3 = 1. Releasing ready → bytes leave in order 0x41..0x48.
- RX overrun: 9 bytes arrive with no reads → `uart_rx_ready` = 0 after 8, STATUS bit2 = 1. Reading RXDATA once → `uart_rx_ready` = 1 the next cycle and the 9th byte is accepted.
- Empty read: RXDATA read with RX FIFO empty → `rdata` = 0, count stays 0, no underflow.
- Simultaneous: on a cycle with RX count = 3, issue an RXDATA read together with a UART push → count stays 3 and the data order is preserved.
- Reset and flush: reset with 4 TX bytes queued → next cycle `uart_tx_valid` = 0 and STATUS = 0x11. A CTRL write of 0x1 with RX holding 2 bytes → RX empty and sticky bits 0.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_pkg
// Description : Address map and STATUS/CTRL bit positions shared by the
//               CPU-to-UART memory-mapped controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // The I/O window is selected by the top address nibble alone.
    localparam logic [3:0] c_base_nibble = 4'h8;

    // Register select, taken from addr[3:2].
    localparam logic [1:0] c_reg_status = 2'd0;
    localparam logic [1:0] c_reg_rxdata = 2'd1;
    localparam logic [1:0] c_reg_txdata = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    // STATUS word bit positions.
    localparam int c_stat_tx_not_full  = 0;
    localparam int c_stat_rx_not_empty = 1;
    localparam int c_stat_rx_overrun   = 2;
    localparam int c_stat_tx_overflow  = 3;
    localparam int c_stat_tx_empty     = 4;

    // CTRL bit that flushes both FIFOs.
    localparam int c_ctrl_flush_bit = 0;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered count; full/empty derive
//               from the count so a push into a full FIFO is refused even
//               when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                   c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]        c_full_count = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointer and count bookkeeping; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_ctrl
// Description : CPU data-port window onto the UART. Decodes 0x8xxx_xxxx,
//               buffers bytes in RX/TX FIFOs, keeps sticky error flags and
//               returns a registered load result.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic                      w_sel;
    logic [1:0]                w_reg;
    logic                      w_rd_rxdata;
    logic                      w_wr_txdata;
    logic                      w_wr_ctrl;
    logic                      w_flush;
    logic                      w_rx_push;
    logic                      w_tx_pop;
    logic [7:0]                w_rx_head;
    logic                      w_rx_full;
    logic                      w_rx_empty;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic [$clog2(RX_DEPTH):0] w_rx_count;
    logic [$clog2(TX_DEPTH):0] w_tx_count;
    logic [31:0]               w_status;
    logic                      w_unused;
    logic                      r_rx_overrun;
    logic                      r_tx_overflow;
    logic [31:0]               r_rdata;

    assign w_sel       = (addr[31:28] == c_base_nibble);
    assign w_reg       = addr[3:2];
    assign w_rd_rxdata = re && w_sel && (w_reg == c_reg_rxdata);
    assign w_wr_txdata = we && w_sel && (w_reg == c_reg_txdata);
    assign w_wr_ctrl   = we && w_sel && (w_reg == c_reg_ctrl);
    assign w_flush     = w_wr_ctrl && wdata[c_ctrl_flush_bit];

    // Ready is held low during reset so the UART never hands over a byte
    // that reset would immediately discard.
    assign uart_rx_ready = !w_rx_full && !rst;
    assign w_rx_push     = uart_rx_valid && uart_rx_ready;
    assign uart_tx_valid = !w_tx_empty;
    assign w_tx_pop      = uart_tx_valid && uart_tx_ready;
    assign rdata         = r_rdata;

    // Address bits outside the decode and the counts are intentionally unused.
    assign w_unused = ^{addr[27:4], addr[1:0], wdata[31:8], w_rx_count, w_tx_count};

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_rx_push),
        .pop   (w_rd_rxdata),
        .din   (uart_rx_data),
        .head  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_wr_txdata),
        .pop   (w_tx_pop),
        .din   (wdata[7:0]),
        .head  (uart_tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    // STATUS snapshot built from registered state, i.e. before this cycle's events.
    always_comb begin
        w_status                      = '0;
        w_status[c_stat_tx_not_full]  = !w_tx_full;
        w_status[c_stat_rx_not_empty] = !w_rx_empty;
        w_status[c_stat_rx_overrun]   = r_rx_overrun;
        w_status[c_stat_tx_overflow]  = r_tx_overflow;
        w_status[c_stat_tx_empty]     = w_tx_empty;
    end

    // Sticky error flags: a same-cycle set wins over a CTRL clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (uart_rx_valid && w_rx_full) r_rx_overrun <= 1'b1;
            else if (w_wr_ctrl)             r_rx_overrun <= 1'b0;
            if (w_wr_txdata && w_tx_full)   r_tx_overflow <= 1'b1;
            else if (w_wr_ctrl)             r_tx_overflow <= 1'b0;
        end
    end

    // Load result register: updated only on re, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            if (!w_sel) begin
                r_rdata <= '0;
            end else begin
                case (w_reg)
                    c_reg_status: r_rdata <= w_status;
                    c_reg_rxdata: r_rdata <= w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                    default:      r_rdata <= '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio_ctrl
// Description : Queue-based reference model with a per-cycle output compare
//               plus directed register-level scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_ctrl;

    localparam int          RXD      = 8;
    localparam int          TXD      = 8;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_CTRL   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int n_vec = 0;
    int n_bad = 0;

    uart_mmio_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte queues and flags, updated at each rising edge
    // ------------------------------------------------------------------
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic [7:0]  tx_seen[$];
    bit          m_ovr = 1'b0;
    bit          m_txo = 1'b0;
    bit          m_live = 1'b0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin : model
        bit          sel;
        logic [1:0]  r;
        bit          rxf;
        bit          txf;
        logic [31:0] st;
        if (rst) begin
            m_rxq.delete();
            m_txq.delete();
            m_ovr   = 1'b0;
            m_txo   = 1'b0;
            m_rdata = '0;
            m_live  = 1'b1;
        end else if (m_live) begin
            sel = (addr[31:28] == 4'h8);
            r   = addr[3:2];
            rxf = (m_rxq.size() == RXD);
            txf = (m_txq.size() == TXD);
            st  = 32'd0;
            if (!txf)               st = st + 32'd1;
            if (m_rxq.size() != 0)  st = st + 32'd2;
            if (m_ovr)              st = st + 32'd4;
            if (m_txo)              st = st + 32'd8;
            if (m_txq.size() == 0)  st = st + 32'd16;
            if (re) begin
                if (sel && r == 2'd0)                         m_rdata = st;
                else if (sel && r == 2'd1 && m_rxq.size() != 0) m_rdata = {24'd0, m_rxq[0]};
                else                                          m_rdata = 32'd0;
            end
            if (uart_rx_valid && rxf)            m_ovr = 1'b1;
            else if (we && sel && r == 2'd3)     m_ovr = 1'b0;
            if (we && sel && r == 2'd2 && txf)   m_txo = 1'b1;
            else if (we && sel && r == 2'd3)     m_txo = 1'b0;
            if (we && sel && r == 2'd3 && wdata[0]) begin
                m_rxq.delete();
                m_txq.delete();
            end else begin
                if (re && sel && r == 2'd1 && m_rxq.size() != 0) void'(m_rxq.pop_front());
                if (uart_rx_valid && !rxf) m_rxq.push_back(uart_rx_data);
                if (m_txq.size() != 0 && uart_tx_ready) void'(m_txq.pop_front());
                if (we && sel && r == 2'd2 && !txf) m_txq.push_back(wdata[7:0]);
            end
        end
    end

    // Per-cycle compare on the falling edge; also plays the off-chip receiver.
    always @(negedge clk) begin
        if (m_live) begin
            check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_txq.size() != 0});
            if (m_txq.size() != 0) check("tx_data", {24'd0, uart_tx_data}, {24'd0, m_txq[0]});
            check("rx_ready", {31'd0, uart_rx_ready}, {31'd0, (!rst && m_rxq.size() < RXD)});
            check("rdata", rdata, m_rdata);
            if (uart_tx_valid && uart_tx_ready) tx_seen.push_back(uart_tx_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        d    = rdata;
    endtask

    task automatic uart_send(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (uart_rx_ready) break;
        end
        check("uart_send_accept", {31'd0, uart_rx_ready}, 32'd1);
        tick();
        uart_rx_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] d;
        d = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        rst = 1'b0;
        cpu_read(A_STATUS, d);
        check("status_after_reset", d, 32'h11);

        // Unselected accesses
        cpu_write(32'h1000_0008, 32'h55);
        cpu_read(32'h0000_0000, d);
        check("unselected_read", d, 32'd0);
        cpu_read(A_TXDATA, d);
        check("read_write_only", d, 32'd0);

        // Echo
        uart_send(8'h7A);
        for (int k = 0; k < 20; k++) begin
            cpu_read(A_STATUS, d);
            if (d[1]) break;
        end
        check("echo_poll_bit1", {31'd0, d[1]}, 32'd1);
        cpu_read(A_RXDATA, d);
        check("echo_rxdata", d, 32'h7A);
        uart_tx_ready = 1'b1;
        cpu_write(A_TXDATA, 32'h7A);
        repeat (3) tick();
        check("echo_tx_count", tx_seen.size(), 32'd1);
        if (tx_seen.size() > 0) check("echo_tx_byte", {24'd0, tx_seen[0]}, 32'h7A);
        tx_seen.delete();

        // Burst TX with ready held low
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) cpu_write(A_TXDATA, 32'h41 + i);
        cpu_read(A_STATUS, d);
        check("burst_status_full", d, 32'h00);
        cpu_write(A_TXDATA, 32'h49);
        cpu_read(A_STATUS, d);
        check("burst_status_overflow", d, 32'h08);
        uart_tx_ready = 1'b1;
        repeat (10) tick();
        uart_tx_ready = 1'b0;
        check("burst_tx_count", tx_seen.size(), 32'd8);
        for (int i = 0; i < 8 && i < tx_seen.size(); i++)
            check("burst_tx_order", {24'd0, tx_seen[i]}, 32'h41 + i);
        tx_seen.delete();
        cpu_write(A_CTRL, 32'h0);

        // RX overrun
        for (int i = 0; i < 8; i++) uart_send(8'h30 + 8'(i));
        uart_rx_data  = 8'h38;
        uart_rx_valid = 1'b1;
        tick();
        tick();
        check("ovr_rx_ready_low", {31'd0, uart_rx_ready}, 32'd0);
        cpu_read(A_STATUS, d);
        check("ovr_status", d, 32'h17);
        cpu_read(A_RXDATA, d);
        check("ovr_first_byte", d, 32'h30);
        check("ovr_ready_after_pop", {31'd0, uart_rx_ready}, 32'd1);
        tick();
        uart_rx_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            cpu_read(A_RXDATA, d);
            check("ovr_drain", d, 32'h30 + i);
        end
        cpu_write(A_CTRL, 32'h0);

        // Empty read
        cpu_read(A_RXDATA, d);
        check("empty_rxdata", d, 32'd0);
        cpu_read(A_STATUS, d);
        check("empty_status", d, 32'h11);

        // Simultaneous pop and push at count 3
        uart_send(8'h51);
        uart_send(8'h52);
        uart_send(8'h53);
        addr          = A_RXDATA;
        re            = 1'b1;
        uart_rx_data  = 8'h54;
        uart_rx_valid = 1'b1;
        tick();
        re            = 1'b0;
        uart_rx_valid = 1'b0;
        check("simul_rdata", rdata, 32'h51);
        for (int i = 2; i < 5; i++) begin
            cpu_read(A_RXDATA, d);
            check("simul_order", d, 32'h50 + i);
        end
        cpu_read(A_STATUS, d);
        check("simul_empty_after_3", d, 32'h11);

        // Reset with TX bytes queued
        for (int i = 0; i < 4; i++) cpu_write(A_TXDATA, 32'h61 + i);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        cpu_read(A_STATUS, d);
        check("reset_status", d, 32'h11);

        // Flush with RX holding 2 bytes and a sticky set
        uart_send(8'h71);
        uart_send(8'h72);
        for (int i = 0; i < 9; i++) cpu_write(A_TXDATA, 32'h80 + i);
        cpu_read(A_STATUS, d);
        check("preflush_status", d, 32'h0A);
        cpu_write(A_CTRL, 32'h1);
        cpu_read(A_STATUS, d);
        check("flush_status", d, 32'h11);
        cpu_read(A_RXDATA, d);
        check("flush_rx_empty", d, 32'd0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
